// File: rtl/qar_pkg.sv
// Shared definitions for the QAR data-memory arbiter: FSM encoding, error
// read data and the constant width helper.
package qar_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } qar_state_t;

   localparam logic [31:0] QAR_ERR_RDATA = 32'hDEADBEEF;

   // Smallest r with 2**r >= value; 0 for value <= 1.
   function automatic int qar_clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/qar_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester that was not served
// last wins; a lone requester always wins.
module qar_rr_arbiter2 (
   input  logic [1:0] i_valid,
   input  logic       i_last,
   output logic       o_any,
   output logic       o_grant
);

   always_comb begin
      o_any   = |i_valid;
      o_grant = 1'b0;
      if (i_valid == 2'b11) begin
         o_grant = ~i_last;
      end else if (i_valid[1]) begin
         o_grant = 1'b1;
      end
   end

endmodule

// File: rtl/qar_dmem_arbiter.sv
// Shares one data-memory port between the core (m0) and a debug/DMA master
// (m1), with round-robin arbitration and a saturating downstream timeout.
module qar_dmem_arbiter
   import qar_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_RDATA      = QAR_ERR_RDATA
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_valid,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        mem_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        grant_id,
   output logic        timeout_err,
   input  logic        err_clr
);

   localparam int CNT_W_RAW = qar_clog2(int'(TIMEOUT_CYCLES) + 1);
   localparam int CNT_W     = (CNT_W_RAW > 0) ? CNT_W_RAW : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

   qar_state_t       r_state;
   qar_state_t       w_state_next;
   logic             r_grant;
   logic             r_last;
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout_err;

   logic             w_any;
   logic             w_grant_next;
   logic             w_req_we;
   logic [31:0]      w_req_addr;
   logic [31:0]      w_req_wdata;
   logic             w_limit;
   logic             w_done;
   logic             w_timeout;
   logic [31:0]      w_rdata;

   qar_rr_arbiter2 u_rr (
      .i_valid (({m1_valid, m0_valid})),
      .i_last  (r_last),
      .o_any   (w_any),
      .o_grant (w_grant_next)
   );

   assign w_req_we    = r_grant ? m1_we    : m0_we;
   assign w_req_addr  = r_grant ? m1_addr  : m0_addr;
   assign w_req_wdata = r_grant ? m1_wdata : m0_wdata;
   assign w_limit     = TMO_EN && (r_cnt == CNT_LIMIT);

   assign busy        = (r_state == ST_BUSY);
   assign grant_id    = r_grant;
   assign timeout_err = r_timeout_err;

   // A late mem_ready in the limit cycle still completes normally, so the
   // timeout path only takes over when the memory stays silent.
   always_comb begin
      w_state_next = r_state;
      w_done       = 1'b0;
      w_timeout    = 1'b0;
      w_rdata      = 32'h0;
      mem_valid    = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = 32'h0;
      mem_wdata    = 32'h0;
      m0_ready     = 1'b0;
      m1_ready     = 1'b0;
      m0_rdata     = 32'h0;
      m1_rdata     = 32'h0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            mem_addr  = w_req_addr;
            mem_wdata = w_req_wdata;
            if (mem_ready) begin
               mem_valid = 1'b1;
               mem_we    = w_req_we;
               w_done    = 1'b1;
               w_rdata   = mem_rdata;
            end else if (w_limit) begin
               w_done    = 1'b1;
               w_timeout = 1'b1;
               w_rdata   = ERR_RDATA;
            end else begin
               mem_valid = 1'b1;
               mem_we    = w_req_we;
            end
            if (w_done) begin
               w_state_next = ST_IDLE;
               m0_ready     = ~r_grant;
               m1_ready     = r_grant;
               m0_rdata     = r_grant ? 32'h0 : w_rdata;
               m1_rdata     = r_grant ? w_rdata : 32'h0;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // After reset r_last points at m1 so that m0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_grant <= 1'b0;
         r_last  <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         if ((r_state == ST_IDLE) && w_any) begin
            r_grant <= w_grant_next;
            r_cnt   <= '0;
         end else if (r_state == ST_BUSY) begin
            if (w_done) begin
               r_last <= r_grant;
            end else if (r_cnt != CNT_LIMIT) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
         r_timeout_err <= 1'b1;
      end else if (err_clr) begin
         r_timeout_err <= 1'b0;
      end
   end

endmodule

// File: doc/qar_dmem_arbiter.md
QAR_DMEM_ARBITER -- requirements
Module: qar_dmem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, downstream-wait limit in cycles; 0 disables the timeout.
REQ-002 Parameter ERR_RDATA, default 32'hDEADBEEF, read data returned on a timed-out load.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 m0_valid/m0_we  input  1/1  core request strobe and write flag.
REQ-006 m0_addr/m0_wdata  input  32/32  core address and store data.
REQ-007 m0_ready  output  1  core completion pulse; m0_rdata  output  32  core load data.
REQ-008 m1_valid/m1_we/m1_addr/m1_wdata  input  1/1/32/32  debug/DMA requester, same meaning as m0.
REQ-009 m1_ready  output  1, m1_rdata  output  32  secondary completion and load data.
REQ-010 mem_valid/mem_we/mem_addr/mem_wdata  output  1/1/32/32  shared DMEM request.
REQ-011 mem_ready/mem_rdata  input  1/32  DMEM completion and load data.
REQ-012 busy  output  1  transaction in flight; grant_id  output  1  owner of the current or last transaction.
REQ-013 timeout_err  output  1  sticky timeout flag; err_clr  input  1  clears timeout_err.

Function
REQ-014 FSM states: IDLE, BUSY.
REQ-015 IDLE: with no mX_valid, stay IDLE; otherwise grant one requester, latch grant_id, clear wait counter, go to BUSY next cycle.
REQ-016 Arbitration round-robin: if both valid, grant the requester not served last; after reset, m0 has priority.
REQ-017 BUSY: mem_valid=1 and mem_we/addr/wdata driven from the granted requester; the requester holds its signals stable until its ready.
REQ-018 Ungranted requester: ready=0 and its request stays pending; no request is dropped.
REQ-019 BUSY with mem_ready=1: granted mX_ready=1 for exactly that cycle, mX_rdata=mem_rdata, last-served pointer updated, return to IDLE.
REQ-020 Latency: mem_valid rises one cycle after a valid request is seen in IDLE; minimum 2 cycles from mX_valid to mX_ready; one IDLE cycle separates back-to-back transactions.
REQ-021 Wait counter increments each BUSY cycle without mem_ready; when it reaches TIMEOUT_CYCLES (nonzero), the arbiter completes the transaction: mX_ready=1, mX_rdata=ERR_RDATA, mem_valid=0, timeout_err set, return to IDLE.
REQ-022 mem_ready and the timeout in the same cycle: mem_ready wins; timeout_err is not set.
REQ-023 err_clr clears timeout_err next cycle; a concurrent new timeout takes priority and keeps the flag set.
REQ-024 Outside BUSY: mem_valid=0, mem_we=0, mX_ready=0; mem_addr/mem_wdata don't-care, driven 0.
REQ-025 mX_rdata=0 except in the completing cycle.
REQ-026 Counter width is clog2(TIMEOUT_CYCLES+1) bits minimum and never wraps; it saturates at the limit.

Reset
REQ-027 rst_n low asynchronously forces IDLE, busy=0, grant_id=0, last-served pointer to m0 priority, counter=0, timeout_err=0, and all mem_*/mX_ready outputs to 0.
REQ-028 Reset during BUSY aborts the transaction silently; no ready pulse follows reset release.

Structure
REQ-029 FSM state encodings, ERR_RDATA default and the clog2 function belong in a shared qar_pkg package.
REQ-030 One sub-module, qar_rr_arbiter2, computes the 2-way round-robin grant from valid bits and the last-served pointer; the rest is flat.

Verification
REQ-031 m0 load to 0x10, mem_ready 1 cycle after mem_valid, mem_rdata=0x12345678 -> m0_ready pulse at cycle 3, m0_rdata=0x12345678, m1_ready stays 0.
REQ-032 m0 and m1 valid together, three times back-to-back -> grant order m0, m1, m0; one IDLE cycle between transactions.
REQ-033 m1 store addr 0x40 data 0xA5A5A5A5, mem_ready delayed 5 cycles -> mem_we=1, address and data stable for all 6 BUSY cycles, m1_ready pulses once.
REQ-034 TIMEOUT_CYCLES=8, mem_ready held 0 -> m0_ready after 8 BUSY cycles, m0_rdata=0xDEADBEEF, timeout_err=1 until err_clr pulse.
REQ-035 mem_ready asserted in the exact timeout cycle -> normal completion, timeout_err stays 0.
REQ-036 rst_n pulsed low mid-BUSY -> all outputs 0 immediately; after release, m0 wins a simultaneous request.
